// File: rtl/control_cmd_write_arbiter.sv
// -----------------------------------------------------------------------------
// control_cmd_write_arbiter
//
// Shares the single framebuffer write port between NUM_REQ command engines
// (fillrect, line, pixel, ...). Engines stream writes with no back-pressure,
// so a grant is held for a whole command: from the request until the engine's
// done pulse. Arbitration is round-robin and the forwarded port is registered.
// Writes from ungranted engines and hung commands raise sticky error flags.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   req                 per-engine command pending/active
//   req_done            per-engine command-complete pulse
//   req_row/column/pixel/data  flattened per-engine address/data buses
//   req_write_enable    per-engine write strobe
//   req_access_start    per-engine access-start strobe
//   grant, grant_id     one-hot grant and index of the (last) grantee
//   busy                a grant is active
//   row/column/pixel/data_out/ram_write_enable/ram_access_start  framebuffer port
//   err_clear           synchronous clear of the sticky errors
//   collision_err       an ungranted engine asserted a write strobe
//   timeout_err         a grant was force-released by the timeout
// -----------------------------------------------------------------------------
package calc;
    function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
        return (bytes_per_pixel > 1) ? $clog2(bytes_per_pixel) : 1;
    endfunction

    function automatic int num_row_address_bits(input int pixel_height);
        return (pixel_height > 1) ? $clog2(pixel_height) : 1;
    endfunction

    function automatic int num_column_address_bits(input int pixel_width);
        return (pixel_width > 1) ? $clog2(pixel_width) : 1;
    endfunction
endpackage

module control_cmd_write_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int PIXEL_HEIGHT    = 16,
    parameter int PIXEL_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES  = 4096,
    localparam int PIX_BITS = calc::num_pixelcolorselect_bits(BYTES_PER_PIXEL),
    localparam int ROW_BITS = calc::num_row_address_bits(PIXEL_HEIGHT),
    localparam int COL_BITS = calc::num_column_address_bits(PIXEL_WIDTH),
    localparam int ID_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_done,
    input  logic [NUM_REQ*ROW_BITS-1:0]  req_row,
    input  logic [NUM_REQ*COL_BITS-1:0]  req_column,
    input  logic [NUM_REQ*PIX_BITS-1:0]  req_pixel,
    input  logic [NUM_REQ*8-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_write_enable,
    input  logic [NUM_REQ-1:0]           req_access_start,
    output logic [NUM_REQ-1:0]           grant,
    output logic [ID_BITS-1:0]           grant_id,
    output logic                         busy,
    output logic [ROW_BITS-1:0]          row,
    output logic [COL_BITS-1:0]          column,
    output logic [PIX_BITS-1:0]          pixel,
    output logic [7:0]                   data_out,
    output logic                         ram_write_enable,
    output logic                         ram_access_start,
    input  logic                         err_clear,
    output logic                         collision_err,
    output logic                         timeout_err
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [ID_BITS-1:0] ID_LAST = ID_BITS'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                state_r;
    logic [CNT_BITS-1:0]   cnt_r;

    logic                  pick_valid_s;
    logic [ID_BITS-1:0]    pick_id_s;
    int                    best_dist_s;
    int                    dist_s;
    logic [ROW_BITS-1:0]   sel_row_s;
    logic [COL_BITS-1:0]   sel_col_s;
    logic [PIX_BITS-1:0]   sel_pix_s;
    logic [7:0]            sel_data_s;
    logic                  sel_we_s;
    logic                  sel_as_s;
    logic                  done_s;
    logic                  held_s;
    logic                  timeout_hit_s;
    logic                  release_s;
    logic [NUM_REQ-1:0]    gmask_s;
    logic                  collision_ev_s;
    logic                  timeout_ev_s;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_BITS-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh     = {NUM_REQ{1'b0}};
        oh[id] = 1'b1;
        return oh;
    endfunction

    // Round-robin pick: the requester closest above grant_id (wrapping) wins.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_id_s    = grant_id;
        best_dist_s  = NUM_REQ;
        dist_s       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_s = (i + NUM_REQ - 1 - int'(grant_id)) % NUM_REQ;
            if (req[i] && (dist_s < best_dist_s)) begin
                best_dist_s  = dist_s;
                pick_id_s    = ID_BITS'(i);
                pick_valid_s = 1'b1;
            end else begin
                best_dist_s  = best_dist_s;
            end
        end
    end

    // AND-OR mux of the granted engine's write port; grant is one-hot or zero.
    always_comb begin
        sel_row_s  = {ROW_BITS{1'b0}};
        sel_col_s  = {COL_BITS{1'b0}};
        sel_pix_s  = {PIX_BITS{1'b0}};
        sel_data_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_row_s  = sel_row_s  | (req_row[i*ROW_BITS +: ROW_BITS]    & {ROW_BITS{grant[i]}});
            sel_col_s  = sel_col_s  | (req_column[i*COL_BITS +: COL_BITS] & {COL_BITS{grant[i]}});
            sel_pix_s  = sel_pix_s  | (req_pixel[i*PIX_BITS +: PIX_BITS]  & {PIX_BITS{grant[i]}});
            sel_data_s = sel_data_s | (req_data[i*8 +: 8]                 & {8{grant[i]}});
        end
        sel_we_s = |(req_write_enable & grant);
        sel_as_s = |(req_access_start & grant);
    end

    // Release conditions and error events.
    always_comb begin
        done_s         = |(req_done & grant);
        held_s         = |(req & grant);
        timeout_hit_s  = TO_EN && (cnt_r == CNT_LAST);
        release_s      = done_s | ~held_s | timeout_hit_s;
        gmask_s        = (state_r == ST_GRANTED) ? grant : {NUM_REQ{1'b0}};
        collision_ev_s = |(req_write_enable & ~gmask_s);
        timeout_ev_s   = (state_r == ST_GRANTED) && timeout_hit_s;
    end

    // Arbitration FSM, registered write port and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= ST_IDLE;
            cnt_r            <= {CNT_BITS{1'b0}};
            grant            <= {NUM_REQ{1'b0}};
            grant_id         <= ID_LAST;
            busy             <= 1'b0;
            row              <= {ROW_BITS{1'b0}};
            column           <= {COL_BITS{1'b0}};
            pixel            <= {PIX_BITS{1'b0}};
            data_out         <= 8'h00;
            ram_write_enable <= 1'b0;
            ram_access_start <= 1'b0;
            collision_err    <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            // A new error event in the same cycle as err_clear keeps the flag set.
            collision_err <= collision_ev_s | (collision_err & ~err_clear);
            timeout_err   <= timeout_ev_s   | (timeout_err   & ~err_clear);

            case (state_r)
                ST_IDLE: begin
                    ram_write_enable <= 1'b0;
                    ram_access_start <= 1'b0;
                    cnt_r            <= {CNT_BITS{1'b0}};
                    if (pick_valid_s) begin
                        grant    <= id_to_onehot(pick_id_s);
                        grant_id <= pick_id_s;
                        busy     <= 1'b1;
                        state_r  <= ST_GRANTED;
                    end else begin
                        grant    <= {NUM_REQ{1'b0}};
                        busy     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_GRANTED: begin
                    // The releasing cycle's write is still forwarded.
                    row              <= sel_row_s;
                    column           <= sel_col_s;
                    pixel            <= sel_pix_s;
                    data_out         <= sel_data_s;
                    ram_write_enable <= sel_we_s;
                    ram_access_start <= sel_as_s;
                    cnt_r            <= cnt_r + CNT_BITS'(1);
                    if (release_s) begin
                        grant   <= {NUM_REQ{1'b0}};
                        busy    <= 1'b0;
                        state_r <= ST_RELEASE;
                    end else begin
                        state_r <= ST_GRANTED;
                    end
                end
                ST_RELEASE: begin
                    // grant_id is kept so the next search starts past it.
                    ram_write_enable <= 1'b0;
                    ram_access_start <= 1'b0;
                    cnt_r            <= {CNT_BITS{1'b0}};
                    grant            <= {NUM_REQ{1'b0}};
                    busy             <= 1'b0;
                    state_r          <= ST_IDLE;
                end
                default: begin
                    ram_write_enable <= 1'b0;
                    ram_access_start <= 1'b0;
                    cnt_r            <= {CNT_BITS{1'b0}};
                    grant            <= {NUM_REQ{1'b0}};
                    busy             <= 1'b0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
